// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher: on-chip forward key expansion to rk10,
// then one inverse round per clock with a reverse key schedule.

package aes_gf_pkg;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// Forward S-box: field inverse followed by the affine transform.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_gf_pkg::*;
   logic [7:0] b;

   // affine(inv(a))
   always_comb begin
      b = gf_inv(a);
      y = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   end
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse.
module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_gf_pkg::*;
   logic [7:0] b;

   // inv(affine^-1(a))
   always_comb begin
      b = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
      y = gf_inv(b);
   end
endmodule

// state  | meaning
// IDLE   | waiting for read_enable, captures data and key
// KEYEXP | forward key schedule, ten steps up to rk10
// ROUND  | inverse rounds 9..0, reverse key schedule alongside
// DONE   | result valid, waits for read_enable low
module aes_decrypt (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] data,
   input  logic [127:0] key,
   input  logic         read_enable,
   output logic [127:0] out_data,
   output logic         done
);
   import aes_gf_pkg::*;

   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_t;

   fsm_t          fsm, fsm_next;
   logic [127:0]  blk, kr;
   logic [3:0]    rnd;
   logic [7:0]    rcon;

   logic [31:0]   kw, kw_rot, kw_sub, kt;
   logic [127:0]  key_fwd, key_rev;
   logic [127:0]  isr, isb, ark, imc;
   logic [7:0]    a0, a1, a2, a3;

   // In ROUND the S-box word is the recovered w3 of the previous round key,
   // so the same four S-boxes serve both schedule directions.
   assign kw     = (fsm == ROUND) ? (kr[127:96] ^ kr[95:64]) : kr[127:96];
   assign kw_rot = {kw[7:0], kw[31:8]};
   assign kt     = kw_sub ^ {24'h0, rcon};

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_key_sbox
         aes_sbox u_sbox (.a(kw_rot[8*g +: 8]), .y(kw_sub[8*g +: 8]));
      end
      for (g = 0; g < 16; g++) begin : g_data
         localparam int ROW = g % 4;
         localparam int SRC = ROW + 4 * (((g / 4) - ROW + 4) % 4);
         assign isr[8*g +: 8] = blk[8*SRC +: 8];
         aes_inv_sbox u_isbox (.a(isr[8*g +: 8]), .y(isb[8*g +: 8]));
      end
   endgenerate

   // one forward and one reverse key-schedule step from the current key
   always_comb begin
      key_fwd[31:0]   = kr[31:0]   ^ kt;
      key_fwd[63:32]  = kr[63:32]  ^ key_fwd[31:0];
      key_fwd[95:64]  = kr[95:64]  ^ key_fwd[63:32];
      key_fwd[127:96] = kr[127:96] ^ key_fwd[95:64];
      key_rev[127:96] = kr[127:96] ^ kr[95:64];
      key_rev[95:64]  = kr[95:64]  ^ kr[63:32];
      key_rev[63:32]  = kr[63:32]  ^ kr[31:0];
      key_rev[31:0]   = kr[31:0]   ^ kt;
   end

   assign ark = isb ^ key_rev;

   // InvMixColumns on the key-added round result
   always_comb begin
      imc = '0;
      a0  = '0;
      a1  = '0;
      a2  = '0;
      a3  = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = ark[32*c      +: 8];
         a1 = ark[32*c + 8  +: 8];
         a2 = ark[32*c + 16 +: 8];
         a3 = ark[32*c + 24 +: 8];
         imc[32*c      +: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
         imc[32*c + 8  +: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
         imc[32*c + 16 +: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
         imc[32*c + 24 +: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_next;
   end

   // next-state logic
   always_comb begin
      fsm_next = fsm;
      case (fsm)
         IDLE:    if (read_enable)  fsm_next = KEYEXP;
         KEYEXP:  if (rnd == 4'd9)  fsm_next = ROUND;
         ROUND:   if (rnd == 4'd0)  fsm_next = DONE;
         DONE:    if (!read_enable) fsm_next = IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   // datapath, key schedule, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk      <= '0;
         kr       <= '0;
         rnd      <= '0;
         rcon     <= '0;
         out_data <= '0;
         done     <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (read_enable) begin
                  blk  <= data;
                  kr   <= key;
                  rnd  <= 4'd0;
                  rcon <= 8'h01;
               end
            end
            KEYEXP: begin
               kr <= key_fwd;
               if (rnd == 4'd9) begin
                  // rcon stays at 0x36: the reverse schedule starts from it
                  blk <= blk ^ key_fwd;
               end else begin
                  rcon <= xtime(rcon);
                  rnd  <= rnd + 4'd1;
               end
            end
            ROUND: begin
               kr   <= key_rev;
               rcon <= rcon[0] ? (((rcon ^ 8'h1b) >> 1) | 8'h80) : (rcon >> 1);
               if (rnd == 4'd0) begin
                  blk      <= ark;
                  out_data <= ark;
                  done     <= 1'b1;
               end else begin
                  blk <= imc;
                  rnd <= rnd - 4'd1;
               end
            end
            DONE: begin
               if (!read_enable) done <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: FIPS vectors, restart/reset behaviour and random
// vectors against a table-driven AES-128 inverse cipher model.
module tb_aes_decrypt;

   logic         clk;
   logic         rst;
   logic [127:0] data;
   logic [127:0] key;
   logic         read_enable;
   logic [127:0] out_data;
   logic         done;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] fsb  [256];
   logic [7:0] fisb [256];

   aes_decrypt dut (
      .clk         (clk),
      .rst         (rst),
      .data        (data),
      .key         (key),
      .read_enable (read_enable),
      .out_data    (out_data),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // FIPS text order (first byte leftmost) -> port order (byte 0 in [7:0])
   function automatic logic [127:0] fips(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127 - 8*i -: 8];
      return r;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 0; x = a; y = b;
      while (y != 0) begin
         if (y[0]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rot8(input logic [7:0] v, input int n);
      logic [15:0] t;
      t = {v, v} << n;
      return t[15:8];
   endfunction

   // S-box tables from the generator-3 walk over GF(2^8)*
   task automatic build_tables();
      logic [7:0] p, q, x;
      p = 8'h01; q = 8'h01;
      for (int n = 0; n < 255; n++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q ^= 8'h09;
         x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
         fsb[p] = x ^ 8'h63;
      end
      fsb[0] = 8'h63;
      for (int i = 0; i < 256; i++) fisb[fsb[i]] = 8'(i);
   endtask

   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] k);
      logic [7:0]   rk [176];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   tmp [4];
      logic [7:0]   coef [4];
      logic [7:0]   rc, sv;
      logic [127:0] r;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      for (int i = 0; i < 16; i++) rk[i] = k[8*i +: 8];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) tmp[j] = rk[4*(i-1) + j];
         if (i % 4 == 0) begin
            sv = tmp[0];
            tmp[0] = fsb[tmp[1]] ^ rc;
            tmp[1] = fsb[tmp[2]];
            tmp[2] = fsb[tmp[3]];
            tmp[3] = fsb[sv];
            rc = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) rk[4*i + j] = rk[4*(i-4) + j] ^ tmp[j];
      end
      for (int i = 0; i < 16; i++) s[i] = ct[8*i +: 8] ^ rk[160 + i];
      for (int rd = 9; rd >= 0; rd--) begin
         for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++)
               t[row + 4*((c + row) % 4)] = s[row + 4*c];
         for (int i = 0; i < 16; i++) t[i] = fisb[t[i]] ^ rk[16*rd + i];
         if (rd > 0) begin
            for (int c = 0; c < 4; c++)
               for (int j = 0; j < 4; j++) begin
                  s[4*c + j] = 0;
                  for (int m = 0; m < 4; m++)
                     s[4*c + j] ^= gmul(coef[(m - j + 4) % 4], t[4*c + m]);
               end
         end else begin
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
      end
      for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
      return r;
   endfunction

   // Called right after the capture edge; counts clocks to done (bounded).
   task automatic wait_done(input logic [127:0] exp, input logic [127:0] hold,
                            input bit scramble, input string tag);
      int lat;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 10) chk({tag, "_hold"}, out_data, hold);
         if (done) begin
            lat = n;
            break;
         end
         if (scramble) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            key  = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      chk({tag, "_lat"}, 128'(lat), 128'd20);
      chk({tag, "_out"}, out_data, exp);
   endtask

   task automatic run(input logic [127:0] d, input logic [127:0] k, input logic [127:0] exp,
                      input logic [127:0] hold, input bit scramble, input string tag);
      @(negedge clk);
      data = d; key = k; read_enable = 1'b1;
      @(posedge clk);
      wait_done(exp, hold, scramble, tag);
   endtask

   task automatic release_re(input logic [127:0] hold, input string tag);
      @(negedge clk);
      read_enable = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_done_fall"}, {127'h0, done}, 128'h0);
      chk({tag, "_out_keep"}, out_data, hold);
   endtask

   logic [127:0] kb, db, pb, kc, dc, pc, dz, rd_d, rd_k;

   initial begin
      build_tables();
      kb = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
      db = fips(128'h3925841d02dc09fbdc118597196a0b32);
      pb = fips(128'h3243f6a8885a308d313198a2e0370734);
      kc = fips(128'h000102030405060708090a0b0c0d0e0f);
      dc = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      pc = fips(128'h00112233445566778899aabbccddeeff);
      dz = fips(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

      rst = 1'b1; read_enable = 1'b0; data = '0; key = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", out_data, 128'h0);
      chk("rst_done", {127'h0, done}, 128'h0);
      @(negedge clk); rst = 1'b0;

      run(db, kb, pb, 128'h0, 1'b0, "appb");
      repeat (5) @(posedge clk);
      #1;
      chk("appb_stay_done", {127'h0, done}, 128'h1);
      chk("appb_stay_out", out_data, pb);
      release_re(pb, "appb");

      run(dc, kc, pc, pb, 1'b0, "c1");
      release_re(pc, "c1");

      // reset seven clocks into an App. B run, then a clean restart
      @(negedge clk);
      data = db; key = kb; read_enable = 1'b1;
      @(posedge clk);
      repeat (7) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      chk("midrst_out", out_data, 128'h0);
      chk("midrst_done", {127'h0, done}, 128'h0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk);
      wait_done(pb, 128'h0, 1'b0, "rst_recover");
      release_re(pb, "rst_recover");

      run(dz, 128'h0, 128'h0, pb, 1'b0, "zero_key");
      release_re(128'h0, "zero_key");

      rd_d = {$urandom, $urandom, $urandom, $urandom};
      rd_k = {$urandom, $urandom, $urandom, $urandom};
      run(rd_d, rd_k, ref_decrypt(rd_d, rd_k), 128'h0, 1'b1, "scramble");
      pz_keep: begin
         logic [127:0] last;
         last = ref_decrypt(rd_d, rd_k);
         release_re(last, "scramble");
         for (int i = 0; i < 8; i++) begin
            rd_d = {$urandom, $urandom, $urandom, $urandom};
            rd_k = {$urandom, $urandom, $urandom, $urandom};
            run(rd_d, rd_k, ref_decrypt(rd_d, rd_k), last, 1'b0, $sformatf("rand%0d", i));
            last = ref_decrypt(rd_d, rd_k);
            release_re(last, $sformatf("rand%0d", i));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
